// File: rtl/viterbi_channel_model.sv
// viterbi_channel_model: registered symbol channel with windowed periodic/burst/random bit-flip injection and damage counters
module viterbi_channel_model #(
  parameter int W = 2,
  parameter int P_LOG2 = 3,
  parameter int WINDOW = 256,
  parameter int CNT_W = 16,
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic [W-1:0]      sym_i,
  input  logic              start_i,
  input  logic [1:0]        mode_i,
  input  logic [W-1:0]      mask_i,
  input  logic [P_LOG2:0]   burst_len_i,
  input  logic [15:0]       thresh_i,
  output logic              valid_o,
  output logic [W-1:0]      sym_o,
  output logic [W-1:0]      err_o,
  output logic              active_o,
  output logic              done_o,
  output logic [CNT_W-1:0]  sym_ct_o,
  output logic [CNT_W-1:0]  err_sym_ct_o,
  output logic [CNT_W-1:0]  bad_bit_ct_o
);
  localparam int KW = ($clog2(WINDOW + 1) > P_LOG2) ? $clog2(WINDOW + 1) : P_LOG2;
  localparam int PW = $clog2(W + 1);
  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;
  state_t state, state_n;
  logic [KW-1:0] k;
  logic [15:0] lfsr;
  logic [1:0] mode;
  logic [W-1:0] mask;
  logic [P_LOG2:0] burst_len;
  logic [15:0] thresh;
  logic acc, hit, last;
  logic [P_LOG2-1:0] ph;
  logic [W-1:0] e;
  logic [PW-1:0] pop;
  logic [CNT_W:0] bad_sum;
  // the start cycle never counts as an accepted symbol, so it passes clean
  always_comb begin
    acc = valid_i && state == ACTIVE && !start_i;
    ph = k[P_LOG2-1:0];
    hit = mode == 2'd1 ? ph == '0 :
          mode == 2'd2 ? {1'b0, ph} < burst_len :
          mode == 2'd3 ? lfsr < thresh : 1'b0;
    e = acc && hit ? mask : '0;
    pop = '0;
    for (int i = 0; i < W; i++) pop = pop + PW'(e[i]);
    bad_sum = {1'b0, bad_bit_ct_o} + (CNT_W + 1)'(pop);
    last = acc && k == KW'(WINDOW - 1);
    state_n = start_i ? ACTIVE : last ? DONE : state;
  end
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_o <= 1'b0;
      sym_o <= '0;
      err_o <= '0;
      k <= '0;
      lfsr <= SEED;
      mode <= '0;
      mask <= '0;
      burst_len <= '0;
      thresh <= '0;
      sym_ct_o <= '0;
      err_sym_ct_o <= '0;
      bad_bit_ct_o <= '0;
    end else begin
      valid_o <= valid_i;
      sym_o <= sym_i ^ e;
      err_o <= e;
      if (start_i) begin
        mode <= mode_i;
        mask <= mask_i;
        burst_len <= burst_len_i;
        thresh <= thresh_i;
        k <= '0;
        lfsr <= SEED;
        sym_ct_o <= '0;
        err_sym_ct_o <= '0;
        bad_bit_ct_o <= '0;
      end else if (acc) begin
        k <= k + 1'b1;
        lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
        sym_ct_o <= sym_ct_o + CNT_W'(sym_ct_o != '1);
        err_sym_ct_o <= err_sym_ct_o + CNT_W'(e != '0 && err_sym_ct_o != '1);
        bad_bit_ct_o <= bad_sum[CNT_W] ? '1 : bad_sum[CNT_W-1:0];
      end
    end
  end
  assign active_o = state == ACTIVE;
  assign done_o = state == DONE;
endmodule

// File: tb/tb_viterbi_channel_model.sv
// tb_viterbi_channel_model: directed checks of injection modes, window control and counters
module tb_viterbi_channel_model;
  logic clk = 0, rst = 1, valid_i = 0, start_i = 0;
  logic [1:0] sym_i = 0, mode_i = 0, mask_i = 0;
  logic [3:0] burst_len_i = 0;
  logic [15:0] thresh_i = 0;
  logic valid_o, active_o, done_o;
  logic [1:0] sym_o, err_o;
  logic [15:0] sym_ct_o, err_sym_ct_o, bad_bit_ct_o;
  int total = 0, bad = 0;
  int mk, mcnt;
  logic [15:0] ml, cth;
  logic [1:0] cmode, cmask;
  logic [3:0] cbl;

  viterbi_channel_model dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .sym_i(sym_i), .start_i(start_i),
    .mode_i(mode_i), .mask_i(mask_i), .burst_len_i(burst_len_i), .thresh_i(thresh_i),
    .valid_o(valid_o), .sym_o(sym_o), .err_o(err_o), .active_o(active_o), .done_o(done_o),
    .sym_ct_o(sym_ct_o), .err_sym_ct_o(err_sym_ct_o), .bad_bit_ct_o(bad_bit_ct_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] s);
    valid_i = v;
    sym_i = s;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] step(input logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction

  function automatic logic [1:0] exp_e();
    int ph = mk % 8;
    logic h;
    h = cmode == 1 ? ph == 0 : cmode == 2 ? ph < int'(cbl) : cmode == 3 ? ml < cth : 1'b0;
    return h ? cmask : 2'b00;
  endfunction

  task automatic cnts(input string tag, input int s, input int e, input int b);
    chk({tag, "_sym_ct"}, sym_ct_o, s);
    chk({tag, "_err_ct"}, err_sym_ct_o, e);
    chk({tag, "_bit_ct"}, bad_bit_ct_o, b);
  endtask

  task automatic arm(input logic [1:0] m, input logic [1:0] mk_, input logic [3:0] bl, input logic [15:0] th);
    start_i = 1;
    mode_i = m; mask_i = mk_; burst_len_i = bl; thresh_i = th;
    drive(1, 2'b10);
    start_i = 0;
    mode_i = 0; mask_i = 0; burst_len_i = 0; thresh_i = 0;
    cmode = m; cmask = mk_; cbl = bl; cth = th;
    mk = 0; ml = 16'hACE1; mcnt = 0;
    chk("start_pass", {valid_o, sym_o, err_o, active_o, done_o}, {1'b1, 2'b10, 2'b00, 1'b1, 1'b0});
    cnts("start", 0, 0, 0);
  endtask

  task automatic feed(input int n, input bit gap, input bit zero);
    logic [1:0] s, ee;
    for (int i = 0; i < n; i++) begin
      if (gap) begin
        drive(0, 2'($urandom));
        chk("gap", {valid_o, err_o}, 0);
      end
      s = zero ? 2'b00 : 2'($urandom);
      ee = exp_e();
      drive(1, s);
      chk("sym", {valid_o, sym_o, err_o, done_o}, {1'b1, s ^ ee, ee, mk == 255});
      if (ee != 0) mcnt++;
      mk++;
      ml = step(ml);
    end
  endtask

  initial begin
    rst = 1;
    drive(1, 2'b11);
    drive(1, 2'b11);
    chk("rst_out", {valid_o, sym_o, err_o, active_o, done_o}, 0);
    cnts("rst", 0, 0, 0);
    rst = 0;
    drive(1, 2'b01);
    chk("idle_pass", {valid_o, sym_o, err_o, active_o}, {1'b1, 2'b01, 2'b00, 1'b0});

    arm(1, 2'b01, 0, 0);
    feed(256, 0, 1);
    cnts("per", 256, 32, 32);
    chk("per_done", {active_o, done_o}, 2'b01);
    for (int i = 0; i < 3; i++) begin
      drive(1, 2'b00);
      chk("done_pass", {sym_o, err_o, done_o}, {2'b00, 2'b00, 1'b1});
    end
    cnts("frozen", 256, 32, 32);

    arm(2, 2'b11, 3, 0);
    feed(256, 0, 0);
    cnts("burst3", 256, 96, 192);
    arm(2, 2'b11, 8, 0);
    feed(256, 0, 0);
    cnts("burst8", 256, 256, 512);
    arm(2, 2'b11, 0, 0);
    feed(256, 0, 0);
    cnts("burst0", 256, 0, 0);

    arm(3, 2'b11, 0, 16'h0000);
    feed(256, 0, 0);
    cnts("rnd0", 256, 0, 0);
    arm(3, 2'b11, 0, 16'hFFFF);
    feed(256, 0, 0);
    cnts("rndff", 256, mcnt, 2 * mcnt);
    chk("rndff_many", mcnt > 200, 1);

    arm(1, 2'b01, 0, 0);
    feed(256, 1, 1);
    cnts("gap", 256, 32, 32);

    arm(1, 2'b01, 0, 0);
    feed(100, 0, 1);
    cnts("pre_restart", 100, 13, 13);
    arm(1, 2'b01, 0, 0);
    feed(256, 0, 1);
    cnts("restart", 256, 32, 32);

    arm(3, 2'b11, 0, 16'h8000);
    feed(50, 0, 0);
    rst = 1;
    drive(1, 2'b11);
    rst = 0;
    chk("midrst_out", {valid_o, active_o, done_o, err_o}, 0);
    cnts("midrst", 0, 0, 0);
    valid_i = 0;
    arm(3, 2'b11, 0, 16'h8000);
    feed(256, 0, 0);
    cnts("rnd8k", 256, mcnt, 2 * mcnt);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/viterbi_channel_model.md
Name: viterbi_channel_model

Overview:
Parametrised channel model between the convolutional encoder output and the Viterbi decoder input in the tx/rx harness. It passes encoder symbols through a one-cycle register and flips selected bits according to a run-time mode: off, periodic, burst or LFSR-random. Injection is confined to an armed window of WINDOW symbols. The block counts symbols, errored symbols and flipped bits so the bench can correlate decoder output with channel damage.

Parameters:
W, 2, symbol width (bits per encoder output symbol)
P_LOG2, 3, log2 of the periodic/burst pattern period (period = 2**P_LOG2 symbols)
WINDOW, 256, number of valid symbols per injection window (>=1)
CNT_W, 16, width of the statistics counters
SEED, 16'hACE1, LFSR reload value (must be nonzero)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
valid_i  in  1  sym_i is a valid encoder symbol this cycle
sym_i  in  W  encoder output symbol
start_i  in  1  arm/restart injection window; samples config inputs
mode_i  in  2  0 off, 1 periodic, 2 burst, 3 random
mask_i  in  W  bits to flip on an errored symbol
burst_len_i  in  P_LOG2+1  errored symbols at the head of each period (mode 2)
thresh_i  in  16  random-mode threshold
valid_o  out  1  registered valid_i
sym_o  out  W  registered sym_i XOR applied error
err_o  out  W  error pattern applied to the current sym_o
active_o  out  1  FSM in ACTIVE
done_o  out  1  FSM in DONE
sym_ct_o  out  CNT_W  valid symbols seen in the current window
err_sym_ct_o  out  CNT_W  symbols with a nonzero error in the current window
bad_bit_ct_o  out  CNT_W  total flipped bits in the current window

Behaviour:
- Reset values: all outputs 0; FSM IDLE; k=0; LFSR=SEED; config registers 0.
- FSM states: IDLE, ACTIVE, DONE.
  - IDLE --start_i--> ACTIVE.
  - ACTIVE --accept valid symbol with k==WINDOW-1--> DONE.
  - DONE --start_i--> ACTIVE.
  - start_i in ACTIVE restarts the window.
- On start_i (any state):
  - Latch mode/mask/burst_len/thresh.
  - Clear k and all three counters.
  - Reload LFSR=SEED.
  - A valid_i in the start_i cycle is passed through without error and is not counted.
- k is the window symbol index. It advances only on valid_i while ACTIVE, so gaps in valid_i do not shift the pattern.
- Error decision per valid symbol in ACTIVE, with ph = k[P_LOG2-1:0]:
  - Mode 0: none.
  - Mode 1: ph==0.
  - Mode 2: ph < burst_len; burst_len 0 means none; burst_len >= 2**P_LOG2 means every symbol.
  - Mode 3: lfsr < thresh; thresh 0 means none.
  - Errored symbol: e = mask, otherwise e = 0. mask 0 counts as no error.
- LFSR: 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1. It steps once per valid symbol in ACTIVE, and the compare uses the pre-step value.
- Outside ACTIVE the block is a pure pass-through: e = 0 and counters hold.
- Latency: exactly 1 cycle.
  - valid_o(t+1) = valid_i(t).
  - sym_o(t+1) = sym_i(t) ^ e.
  - err_o(t+1) = e.
  - When valid_i=0, sym_o/err_o still register the data but err_o is forced to 0.
- Counters update in the same cycle as sym_o, for symbols accepted in ACTIVE:
  - sym_ct += 1.
  - err_sym_ct += (e != 0).
  - bad_bit_ct += popcount(e).
  - All counters saturate at 2**CNT_W-1; they do not wrap.
- done_o is high from the cycle after the final window symbol until the next start_i or rst. Counters stay frozen while done_o is high.
- rst mid-window: everything returns to reset values at the next edge, and the pipeline output is cleared (valid_o=0).
- Config inputs are ignored except in the start_i cycle.

Test Plan:
- rst, start_i with mode=1, mask=01, WINDOW=256, P_LOG2=3, 256 back-to-back symbols of 2'b00 -> sym_o=01 exactly at k=0,8,...,248; err_sym_ct=32, bad_bit_ct=32, sym_ct=256; done_o high after the last symbol.
- mode=2, burst_len=3, mask=11 -> errors at ph 0..2 of each period; err_sym_ct=96, bad_bit_ct=192. Repeat with burst_len=8 -> 256/512. Repeat with burst_len=0 -> 0/0.
- mode=3, thresh=0 -> no errors, sym_o==sym_i delayed by 1. thresh=16'hFFFF -> err_sym_ct equals a model LFSR count, and err_o matches the model symbol by symbol.
- mode=1, valid_i asserted every other cycle -> same error indices and counts as the back-to-back case; valid_o is valid_i delayed by 1.
- start_i reasserted at k=100, then the full window completes -> counters reflect only the second window (sym_ct=256). The symbol in the start_i cycle is uncounted and unerrored.
- rst asserted at k=50 -> next cycle: all counters 0, valid_o=0, active_o=0. A subsequent start_i reproduces the LFSR sequence from SEED.
